// File: rtl/adc_interface_pkg.sv
// Shared definitions for the ADC front-end control block: register map,
// amplifier gain and input-select encodings, and their pin decoders.
package adc_interface_pkg;

  localparam logic [3:0] ADDR_LED    = 4'd0;
  localparam logic [3:0] ADDR_OE     = 4'd1;
  localparam logic [3:0] ADDR_GAINA  = 4'd2;
  localparam logic [3:0] ADDR_GAINB  = 4'd3;
  localparam logic [3:0] ADDR_INSEL  = 4'd4;
  localparam logic [3:0] ADDR_CHA_EN = 4'd5;
  localparam logic [3:0] ADDR_CHB_EN = 4'd6;
  localparam logic [3:0] ADDR_MON    = 4'd7;
  localparam logic [3:0] ADDR_SAMPLE = 4'd8;
  localparam logic [3:0] ADDR_USER   = 4'd9;

  typedef enum logic [1:0] {
    GAIN_2X   = 2'd0,
    GAIN_3P5X = 2'd1,
    GAIN_8P5X = 2'd2,
    GAIN_OFF  = 2'd3
  } gain_e;

  typedef enum logic [1:0] {
    INSEL_A_IN1  = 2'd0,
    INSEL_A_IN3  = 2'd1,
    INSEL_A_IN4  = 2'd2,
    INSEL_A_NONE = 2'd3
  } insel_a_e;

  typedef enum logic [1:0] {
    INSEL_B_IN1  = 2'd0,
    INSEL_B_IN2  = 2'd1,
    INSEL_B_IN4  = 2'd2,
    INSEL_B_NONE = 2'd3
  } insel_b_e;

  typedef struct packed {
    logic pd_2x_n;
    logic pd_3p5x_n;
    logic pd_8p5x_n;
  } amp_pd_t;

  // Only the selected amplifier is released from power-down; GAIN_OFF parks all.
  function automatic amp_pd_t gain_decode(input logic [1:0] gain);
    amp_pd_t pd;
    pd = '0;
    case (gain)
      GAIN_2X:   pd.pd_2x_n   = 1'b1;
      GAIN_3P5X: pd.pd_3p5x_n = 1'b1;
      GAIN_8P5X: pd.pd_8p5x_n = 1'b1;
      default:   pd = '0;
    endcase
    return pd;
  endfunction

  // Returns {first, second, third} input select, one-hot or all zero.
  function automatic logic [2:0] insel_a_decode(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      INSEL_A_IN1: oh = 3'b100;
      INSEL_A_IN3: oh = 3'b010;
      INSEL_A_IN4: oh = 3'b001;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [2:0] insel_b_decode(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      INSEL_B_IN1: oh = 3'b100;
      INSEL_B_IN2: oh = 3'b010;
      INSEL_B_IN4: oh = 3'b001;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/adc_sample_capture.sv
// Captures the ADC parallel sample on each rising DCO edge, with DCO treated
// as an asynchronous input resynchronised into main_clk.
module adc_sample_capture (
  input  logic       main_clk,
  input  logic       reset_n,
  input  logic [7:0] d,
  input  logic       dco,
  output logic [7:0] sample
);

  logic [1:0] dco_sync;
  logic       dco_prev;
  logic [7:0] d_dly1;
  logic [7:0] d_dly2;
  logic       dco_rise;

  // D is delayed by the same two stages as DCO so the captured word lines up.
  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      dco_sync <= 2'b00;
      dco_prev <= 1'b0;
      d_dly1   <= 8'h00;
      d_dly2   <= 8'h00;
    end else begin
      dco_sync <= {dco_sync[0], dco};
      dco_prev <= dco_sync[1];
      d_dly1   <= d;
      d_dly2   <= d_dly1;
    end
  end

  assign dco_rise = dco_sync[1] & ~dco_prev;

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      sample <= 8'h00;
    end else if (dco_rise) begin
      sample <= d_dly2;
    end
  end

endmodule

// File: rtl/adc_interface.sv
// Avalon-MM register file driving the ADC front-end pins, with sample and
// user-input readback. The ADC serial port is parked idle for pin-strap mode.
module adc_interface
  import adc_interface_pkg::*;
(
  input  logic       main_clk,
  input  logic       reset_n,
  input  logic [3:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic [7:0] D,
  input  logic       DCO,
  output logic       ADC_CSBn,
  output logic       ADC_SDIO,
  output logic       ADC_SCLK,
  output logic       ADC_SDOn,
  output logic       ADC_OEn,
  output logic       CHA_2X_PDn,
  output logic       CHA_3P5X_PDn,
  output logic       CHA_8P5X_PDn,
  output logic       CHA_IN1,
  output logic       CHA_IN3,
  output logic       CHA_IN4,
  output logic       CHA_EN,
  output logic       CHB_2X_PDn,
  output logic       CHB_3P5X_PDn,
  output logic       CHB_8P5X_PDn,
  output logic       CHB_IN1,
  output logic       CHB_IN2,
  output logic       CHB_IN4,
  output logic       CHB_EN,
  output logic       MON_EN,
  output logic       MON_FS,
  input  logic       button1,
  input  logic       button2,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  output logic [7:0] led
);

  logic [7:0] led_reg;
  logic       oe_reg;
  logic [1:0] gain_a;
  logic [1:0] gain_b;
  logic [1:0] insel_a;
  logic [1:0] insel_b;
  logic       cha_en_reg;
  logic       chb_en_reg;
  logic       mon_en_reg;
  logic       mon_fs_reg;
  logic [7:0] sample;
  logic [7:0] rd_mux;
  amp_pd_t    cha_pd;
  amp_pd_t    chb_pd;

  adc_sample_capture u_capture (
    .main_clk (main_clk),
    .reset_n  (reset_n),
    .d        (D),
    .dco      (DCO),
    .sample   (sample)
  );

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      led_reg    <= 8'h00;
      oe_reg     <= 1'b0;
      gain_a     <= 2'b00;
      gain_b     <= 2'b00;
      insel_a    <= 2'b00;
      insel_b    <= 2'b00;
      cha_en_reg <= 1'b0;
      chb_en_reg <= 1'b0;
      mon_en_reg <= 1'b0;
      mon_fs_reg <= 1'b0;
    end else if (write) begin
      case (address)
        ADDR_LED:    led_reg    <= writedata;
        ADDR_OE:     oe_reg     <= writedata[0];
        ADDR_GAINA:  gain_a     <= writedata[1:0];
        ADDR_GAINB:  gain_b     <= writedata[1:0];
        ADDR_INSEL: begin
          insel_a <= writedata[1:0];
          insel_b <= writedata[5:4];
        end
        ADDR_CHA_EN: cha_en_reg <= writedata[0];
        ADDR_CHB_EN: chb_en_reg <= writedata[0];
        ADDR_MON: begin
          mon_en_reg <= writedata[0];
          mon_fs_reg <= writedata[1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (address)
      ADDR_LED:    rd_mux = led_reg;
      ADDR_OE:     rd_mux = {7'b0, oe_reg};
      ADDR_GAINA:  rd_mux = {6'b0, gain_a};
      ADDR_GAINB:  rd_mux = {6'b0, gain_b};
      ADDR_INSEL:  rd_mux = {2'b00, insel_b, 2'b00, insel_a};
      ADDR_CHA_EN: rd_mux = {7'b0, cha_en_reg};
      ADDR_CHB_EN: rd_mux = {7'b0, chb_en_reg};
      ADDR_MON:    rd_mux = {6'b0, mon_fs_reg, mon_en_reg};
      ADDR_SAMPLE: rd_mux = sample;
      ADDR_USER:   rd_mux = {3'b000, switch3, switch2, switch1, button2, button1};
      default:     rd_mux = 8'h00;
    endcase
  end

  // A read alongside a write returns the register contents before the write.
  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 8'h00;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

  assign cha_pd = gain_decode(gain_a);
  assign chb_pd = gain_decode(gain_b);

  assign ADC_CSBn = 1'b1;
  assign ADC_SDIO = 1'b0;
  assign ADC_SCLK = 1'b0;
  assign ADC_SDOn = 1'b1;

  assign led     = led_reg;
  assign ADC_OEn = ~oe_reg;

  assign CHA_2X_PDn   = cha_pd.pd_2x_n;
  assign CHA_3P5X_PDn = cha_pd.pd_3p5x_n;
  assign CHA_8P5X_PDn = cha_pd.pd_8p5x_n;
  assign {CHA_IN1, CHA_IN3, CHA_IN4} = insel_a_decode(insel_a);
  assign CHA_EN = cha_en_reg;

  assign CHB_2X_PDn   = chb_pd.pd_2x_n;
  assign CHB_3P5X_PDn = chb_pd.pd_3p5x_n;
  assign CHB_8P5X_PDn = chb_pd.pd_8p5x_n;
  assign {CHB_IN1, CHB_IN2, CHB_IN4} = insel_b_decode(insel_b);
  assign CHB_EN = chb_en_reg;

  assign MON_EN = mon_en_reg;
  assign MON_FS = mon_fs_reg;

endmodule

// File: tb/tb_adc_interface.sv
// Scoreboard bench for adc_interface: reads push expected data from a
// register-array model; a monitor pops and compares when readdata is due.
module tb_adc_interface;

  logic       main_clk;
  logic       reset_n;
  logic [3:0] address;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic [7:0] D;
  logic       DCO;
  logic       ADC_CSBn, ADC_SDIO, ADC_SCLK, ADC_SDOn, ADC_OEn;
  logic       CHA_2X_PDn, CHA_3P5X_PDn, CHA_8P5X_PDn, CHA_IN1, CHA_IN3, CHA_IN4, CHA_EN;
  logic       CHB_2X_PDn, CHB_3P5X_PDn, CHB_8P5X_PDn, CHB_IN1, CHB_IN2, CHB_IN4, CHB_EN;
  logic       MON_EN, MON_FS;
  logic       button1, button2, switch1, switch2, switch3;
  logic [7:0] led;

  adc_interface dut (
    .main_clk(main_clk), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata), .D(D), .DCO(DCO),
    .ADC_CSBn(ADC_CSBn), .ADC_SDIO(ADC_SDIO), .ADC_SCLK(ADC_SCLK), .ADC_SDOn(ADC_SDOn),
    .ADC_OEn(ADC_OEn),
    .CHA_2X_PDn(CHA_2X_PDn), .CHA_3P5X_PDn(CHA_3P5X_PDn), .CHA_8P5X_PDn(CHA_8P5X_PDn),
    .CHA_IN1(CHA_IN1), .CHA_IN3(CHA_IN3), .CHA_IN4(CHA_IN4), .CHA_EN(CHA_EN),
    .CHB_2X_PDn(CHB_2X_PDn), .CHB_3P5X_PDn(CHB_3P5X_PDn), .CHB_8P5X_PDn(CHB_8P5X_PDn),
    .CHB_IN1(CHB_IN1), .CHB_IN2(CHB_IN2), .CHB_IN4(CHB_IN4), .CHB_EN(CHB_EN),
    .MON_EN(MON_EN), .MON_FS(MON_FS),
    .button1(button1), .button2(button2), .switch1(switch1), .switch2(switch2),
    .switch3(switch3), .led(led)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] regs_m [0:7];
  logic [7:0] sample_m;
  logic [7:0] mon_exp;
  logic       rd_q1;

  // Reference model: stored bytes per address, pins derived arithmetically.
  function automatic logic [2:0] onehot_sel(input logic [1:0] s);
    return (s == 2'd3) ? 3'b000 : (3'b100 >> s);
  endfunction

  function automatic logic [28:0] exp_pins();
    return {regs_m[0], ~regs_m[1][0],
            onehot_sel(regs_m[2][1:0]), onehot_sel(regs_m[4][1:0]), regs_m[5][0],
            onehot_sel(regs_m[3][1:0]), onehot_sel(regs_m[4][5:4]), regs_m[6][0],
            regs_m[7][0], regs_m[7][1], 4'b1001};
  endfunction

  function automatic logic [28:0] got_pins();
    return {led, ADC_OEn,
            CHA_2X_PDn, CHA_3P5X_PDn, CHA_8P5X_PDn, CHA_IN1, CHA_IN3, CHA_IN4, CHA_EN,
            CHB_2X_PDn, CHB_3P5X_PDn, CHB_8P5X_PDn, CHB_IN1, CHB_IN2, CHB_IN4, CHB_EN,
            MON_EN, MON_FS, ADC_CSBn, ADC_SDIO, ADC_SCLK, ADC_SDOn};
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    if (a < 8)  return regs_m[a];
    if (a == 8) return sample_m;
    if (a == 9) return {3'b000, switch3, switch2, switch1, button2, button1};
    return 8'h00;
  endfunction

  task automatic model_wr(input int a, input logic [7:0] d);
    logic [7:0] mask [0:7] = '{8'hFF, 8'h01, 8'h03, 8'h03, 8'h33, 8'h01, 8'h01, 8'h03};
    if (a < 8) regs_m[a] = d & mask[a];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) regs_m[i] = 8'h00;
    sample_m = 8'h00;
  endtask

  task automatic check_pins(input string name);
    logic [28:0] e, g;
    e = exp_pins();
    g = got_pins();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: pins got %b expected %b", name, g, e);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] g, input logic [7:0] e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, g, e);
    end
  endtask

  always @(posedge main_clk or negedge reset_n)
    if (!reset_n) rd_q1 <= 1'b0;
    else          rd_q1 <= read;

  // Monitor: readdata is due the cycle after each read strobe.
  always @(negedge main_clk) begin
    if (rd_q1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL readdata_unexpected: got %h with empty scoreboard", readdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (readdata !== mon_exp) begin
          miscompares++;
          $display("FAIL readdata: got %h expected %h", readdata, mon_exp);
        end
      end
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic randomize_user();
    {switch3, switch2, switch1, button2, button1} = 5'($urandom);
  endtask

  task automatic do_write(input int a, input logic [7:0] d, input string name);
    address = 4'(a); writedata = d; write = 1'b1;
    @(posedge main_clk); #1;
    write = 1'b0;
    model_wr(a, d);
    check_pins(name);
  endtask

  task automatic do_read(input int a);
    address = 4'(a); read = 1'b1;
    exp_q.push_back(model_rd(a));
    @(posedge main_clk); #1;
    read = 1'b0;
  endtask

  task automatic do_rw(input int a, input logic [7:0] d);
    address = 4'(a); writedata = d; read = 1'b1; write = 1'b1;
    exp_q.push_back(model_rd(a));
    @(posedge main_clk); #1;
    read = 1'b0; write = 1'b0;
    model_wr(a, d);
    check_pins("rw_pins");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge main_clk); #1;
    end
  endtask

  // One DCO pulse with data v; the sample is readable four cycles after the rise.
  task automatic dco_pulse(input logic [7:0] v);
    D = v; DCO = 1'b1;
    @(posedge main_clk); #1;
    DCO = 1'b0;
    idle(2);
    sample_m = v;
  endtask

  logic [7:0] gv;

  initial begin
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    D = 8'h00; DCO = 1'b0;
    {switch3, switch2, switch1, button2, button1} = 5'b10110;
    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(1);

    check_pins("reset_pins");
    check8("reset_readdata", readdata, 8'h00);
    for (int a = 0; a < 10; a++) do_read(a);

    do_write(0, 8'hAA, "led_aa");
    check8("led_aa_direct", led, 8'hAA);
    do_read(0);

    for (int g = 0; g < 4; g++) do_write(2, 8'(g), "gain_a");
    for (int g = 0; g < 4; g++) do_write(3, 8'(g), "gain_b");
    do_write(4, 8'h21, "insel_21");
    check8("insel_21_direct", {5'b0, CHA_IN3, CHB_IN4, CHA_IN1}, 8'h06);
    do_write(1, 8'h01, "oe");
    do_write(5, 8'h01, "cha_en");
    do_write(6, 8'h01, "chb_en");
    do_write(7, 8'h01, "mon_en");
    do_write(7, 8'h02, "mon_fs");
    for (int a = 0; a < 8; a++) do_read(a);

    D = 8'h5C;
    for (int i = 0; i < 8; i++) begin
      DCO = ~DCO;
      idle(1);
    end
    DCO = 1'b0;
    sample_m = 8'h5C;
    do_read(8);
    do_write(8, 8'hFF, "sample_wr_ignored");
    do_read(8);

    for (int i = 0; i < 4; i++) begin
      dco_pulse(8'($urandom));
      do_read(8);
    end
    D = 8'($urandom);
    idle(6);
    do_read(8);

    for (int i = 0; i < 200; i++) begin
      int op, a;
      op = $urandom_range(0, 3);
      a  = $urandom_range(0, 15);
      randomize_user();
      case (op)
        0:       do_write(a, 8'($urandom), "rand_write");
        1:       do_read(a);
        2:       do_rw(a, 8'($urandom));
        default: begin dco_pulse(8'($urandom)); do_read(8); end
      endcase
    end

    // Asynchronous reset between clock edges must clear pins at once.
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_pins("async_reset_pins");
    check8("async_reset_readdata", readdata, 8'h00);
    idle(2);
    reset_n = 1'b1;
    for (int a = 0; a < 10; a++) begin
      randomize_user();
      do_read(a);
    end

    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
